// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package mole_pkg;

    localparam int KEY_W = 16;
    localparam int IDX_W = 4;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_UP   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick mole positions.
module lfsr16
    import mole_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = ^(r_q & LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= {w_fb, r_q[15:1]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: timed mole windows, hit/miss scoring, one done pulse per game.
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int TICK_DIV   = 50_000,
    parameter int MOLE_MS    = 1000,
    parameter int GAP_MS     = 200,
    parameter int GAME_MOLES = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_evt,
    output logic [KEY_W-1:0] mole_led,
    output logic [7:0]       score,
    output logic [7:0]       miss_cnt,
    output logic             busy,
    output logic             done,
    output state_t           o_dbg_state
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int T_MAX = (MOLE_MS > GAP_MS) ? MOLE_MS : GAP_MS;
    localparam int TCK_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [PRE_W-1:0] r_presc;
    logic [TCK_W-1:0] r_ticks;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_new_idx;
    logic [KEY_W-1:0] r_mole_led;
    logic [7:0]       r_score;
    logic [7:0]       r_miss;
    logic [7:0]       r_mole_cnt;
    logic [15:0]      w_lfsr;
    logic             w_lfsr_unused;
    logic             w_tick;
    logic             w_gap_exp;
    logic             w_up_exp;
    logic             w_hit;
    logic             w_wrong;
    logic             w_last;
    logic             w_busy;
    logic             w_done;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[15:IDX_W];

    assign w_tick    = (r_presc == PRE_W'(TICK_DIV - 1));
    assign w_gap_exp = w_tick && (r_ticks == TCK_W'(GAP_MS - 1));
    assign w_up_exp  = w_tick && (r_ticks == TCK_W'(MOLE_MS - 1));
    assign w_hit     = key_evt[r_idx];
    assign w_wrong   = (|key_evt) && !w_hit;
    assign w_last    = (r_mole_cnt == 8'(GAME_MOLES - 1));

    // Never show the same position twice in a row.
    assign w_new_idx = (w_lfsr[IDX_W-1:0] == r_idx) ? w_lfsr[IDX_W-1:0] + IDX_W'(1)
                                                     : w_lfsr[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_GAP;
            ST_GAP:  if (w_gap_exp) w_next_state = ST_UP;
            ST_UP: begin
                if (w_hit || w_up_exp) begin
                    w_next_state = w_last ? ST_DONE : ST_GAP;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == ST_GAP) || (r_state == ST_UP);
        w_done = (r_state == ST_DONE);
    end

    // Timer restarts on every state change; a wrong key keeps UP and so keeps the timer running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_ticks <= '0;
        end else if ((w_next_state != r_state) || (r_state == ST_IDLE)) begin
            r_presc <= '0;
            r_ticks <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_ticks <= r_ticks + TCK_W'(1);
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_mole_led <= '0;
            r_score    <= '0;
            r_miss     <= '0;
            r_mole_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_score    <= '0;
                        r_miss     <= '0;
                        r_mole_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (w_gap_exp) begin
                        r_idx      <= w_new_idx;
                        r_mole_led <= KEY_W'(1) << w_new_idx;
                    end
                end
                ST_UP: begin
                    // A hit on the timeout cycle still counts as a hit.
                    if (w_hit) begin
                        r_score    <= sat_inc(r_score);
                        r_mole_cnt <= r_mole_cnt + 8'd1;
                        r_mole_led <= '0;
                    end else if (w_up_exp) begin
                        r_miss     <= sat_inc(r_miss);
                        r_mole_cnt <= r_mole_cnt + 8'd1;
                        r_mole_led <= '0;
                    end else if (w_wrong) begin
                        r_miss <= sat_inc(r_miss);
                    end
                end
                default: r_mole_led <= '0;
            endcase
        end
    end

    assign mole_led    = r_mole_led;
    assign score       = r_score;
    assign miss_cnt    = r_miss;
    assign busy        = w_busy;
    assign done        = w_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl: small-timing instance for game flow, long-game instance for saturation.
module tb_mole_game_ctrl;
  import mole_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance: TICK_DIV=4, MOLE_MS=5, GAP_MS=2 -> UP 20 cycles, GAP 8 cycles
  logic        start;
  logic [15:0] key_evt;
  logic [15:0] mole_led;
  logic [7:0]  score;
  logic [7:0]  miss_cnt;
  logic        busy;
  logic        done;
  state_t      dbg_state;

  mole_game_ctrl #(.TICK_DIV(4), .MOLE_MS(5), .GAP_MS(2), .GAME_MOLES(3)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key_evt     (key_evt),
    .mole_led    (mole_led),
    .score       (score),
    .miss_cnt    (miss_cnt),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // saturation instance: 255 moles, 1-cycle GAP, 3-cycle UP
  logic        s_start;
  logic [15:0] s_key;
  logic [15:0] s_led;
  logic [7:0]  s_score;
  logic [7:0]  s_miss;
  logic        s_busy;
  logic        s_done;
  state_t      s_state;

  mole_game_ctrl #(.TICK_DIV(1), .MOLE_MS(3), .GAP_MS(1), .GAME_MOLES(255)) u_sat (
    .clk         (clk),
    .rst         (rst),
    .start       (s_start),
    .key_evt     (s_key),
    .mole_led    (s_led),
    .score       (s_score),
    .miss_cnt    (s_miss),
    .busy        (s_busy),
    .done        (s_done),
    .o_dbg_state (s_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // reference LFSR, x^16+x^14+x^13+x^11+1, seed ACE1, steps every cycle
  logic [15:0] m_lfsr;
  logic [15:0] m_lfsr_d;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr   <= 16'hACE1;
      m_lfsr_d <= 16'hACE1;
    end else begin
      m_lfsr_d <= m_lfsr;
      m_lfsr   <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  // every new mole must be 1 << idx predicted from the LFSR value it was latched from
  logic [15:0] m_prev_led;
  logic [3:0]  m_prev_idx;
  logic [3:0]  m_cand;
  always @(negedge clk) begin
    if (rst) begin
      m_prev_idx = 4'd0;
      m_prev_led = 16'd0;
    end else begin
      if (mole_led != 16'd0 && m_prev_led == 16'd0) begin
        m_cand = m_lfsr_d[3:0];
        if (m_cand == m_prev_idx) m_cand = m_cand + 4'd1;
        exp_q.push_back(16'd1 << m_cand);
        check("mole_idx", mole_led, exp_q.pop_front());
        m_prev_idx = m_cand;
      end
      m_prev_led = mole_led;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [15:0] k);
    key_evt = k;
    @(negedge clk);
    key_evt = 16'd0;
  endtask

  task automatic wait_mole(output logic [15:0] led);
    int w;
    w = 0;
    while (mole_led == 16'd0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("wait_mole", {31'd0, mole_led != 16'd0}, 32'd1);
    led = mole_led;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] led;
  int g;
  int l;
  int dc;
  logic s_wrap;
  logic [7:0] s_prev_miss;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    key_evt = 16'd0;
    s_start = 1'b0;
    s_key = 16'd0;
    tick(2);
    check("rst_led", mole_led, 0);
    check("rst_score", score, 0);
    check("rst_miss", miss_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    tick(3);
    press(16'hFFFF);
    check("idle_key_score", score, 0);
    check("idle_key_miss", miss_cnt, 0);
    check("idle_busy", busy, 0);

    // full-hit game, key 3 cycles after each mole appears
    pulse_start();
    check("g1_busy", busy, 1);
    for (int m = 0; m < 3; m++) begin
      wait_mole(led);
      tick(3);
      press(led);
      check("g1_led_off", mole_led, 0);
      check("g1_score", score, m + 1);
      if (m < 2) check("g1_busy_gap", busy, 1);
    end
    check("g1_done", done, 1);
    check("g1_busy_done", busy, 0);
    tick(1);
    check("g1_done_low", done, 0);
    check("g1_state_idle", dbg_state, ST_IDLE);
    check("g1_final_score", score, 3);
    check("g1_final_miss", miss_cnt, 0);
    check("g1_done_cnt", done_cnt, 1);

    // timeout-only game: exact GAP and UP lengths
    pulse_start();
    check("g2_score_clr", score, 0);
    for (int m = 0; m < 3; m++) begin
      g = 0;
      while (mole_led == 16'd0 && g < 100) begin
        g++;
        @(negedge clk);
      end
      check("g2_gap_len", g, 8);
      l = 0;
      while (mole_led != 16'd0 && l < 100) begin
        l++;
        @(negedge clk);
      end
      check("g2_up_len", l, 20);
      check("g2_miss", miss_cnt, m + 1);
    end
    check("g2_done", done, 1);
    tick(1);
    check("g2_score", score, 0);
    check("g2_miss_hold", miss_cnt, 3);
    check("g2_done_cnt", done_cnt, 2);

    // wrong key then right key; then a wrong key that must not restart the timer
    pulse_start();
    check("g3_miss_clr", miss_cnt, 0);
    wait_mole(led);
    press(~led);
    check("g3_wrong_miss", miss_cnt, 1);
    check("g3_still_lit", mole_led, led);
    press(led);
    check("g3_hit_score", score, 1);
    check("g3_hit_miss", miss_cnt, 1);
    check("g3_hit_off", mole_led, 0);
    wait_mole(led);
    l = 0;
    while (mole_led != 16'd0 && l < 100) begin
      l++;
      key_evt = (l == 5) ? ~led : 16'd0;
      @(negedge clk);
    end
    key_evt = 16'd0;
    check("g3_no_restart", l, 20);
    check("g3_miss2", miss_cnt, 3);
    wait_mole(led);
    press(led);
    check("g3_done", done, 1);
    tick(1);
    check("g3_score", score, 2);
    check("g3_miss", miss_cnt, 3);

    // key on the timeout cycle counts as a hit
    pulse_start();
    wait_mole(led);
    l = 0;
    while (mole_led != 16'd0 && l < 100) begin
      l++;
      key_evt = (l == 20) ? led : 16'd0;
      @(negedge clk);
    end
    key_evt = 16'd0;
    check("g4_collide_len", l, 20);
    check("g4_collide_score", score, 1);
    check("g4_collide_miss", miss_cnt, 0);
    for (int m = 0; m < 2; m++) begin
      wait_mole(led);
      press(led);
    end
    tick(1);
    check("g4_score", score, 3);
    check("g4_miss", miss_cnt, 0);

    // start while busy ignored; reset during UP aborts with no done
    pulse_start();
    wait_mole(led);
    press(led);
    wait_mole(led);
    pulse_start();
    check("g5_busy_start_score", score, 1);
    check("g5_busy_start_busy", busy, 1);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    check("g5_rst_led", mole_led, 0);
    check("g5_rst_score", score, 0);
    check("g5_rst_busy", busy, 0);
    check("g5_rst_done", done, 0);
    tick(2);
    rst = 1'b0;
    tick(60);
    check("g5_no_done", done_cnt, dc);
    check("g5_idle", dbg_state, ST_IDLE);
    check("g5_busy_low", busy, 0);

    // 255-mole game flooded with wrong keys: miss count must pin at 255
    s_wrap = 1'b0;
    s_prev_miss = 8'd0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    g = 0;
    while (s_done !== 1'b1 && g < 3000) begin
      s_key = (s_led != 16'd0) ? ~s_led : 16'd0;
      if (s_miss < s_prev_miss) s_wrap = 1'b1;
      s_prev_miss = s_miss;
      @(negedge clk);
      g++;
    end
    s_key = 16'd0;
    check("sat_done", s_done, 1);
    check("sat_miss", s_miss, 255);
    check("sat_score", s_score, 0);
    check("sat_no_wrap", s_wrap, 0);
    tick(1);
    check("sat_idle_hold", s_miss, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
